// File: rtl/nla_pkg.sv
// Shared definitions for the non-linear approximation stage: FSM states and
// the default word width / coefficient count also used by the CoeffROM.
package nla_pkg;

  localparam int unsigned NLA_DATA_W     = 32;
  localparam int unsigned NLA_NUM_COEFFS = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RELOAD,
    ST_FETCH,
    ST_CAPTURE,
    ST_ISSUE,
    ST_WAIT_FMA,
    ST_DONE
  } nla_state_e;

endpackage

// File: rtl/horner_sequencer.sv
// Evaluates a polynomial by Horner's rule, streaming coefficients from an
// external ROM (highest order first) through an external a*b+c FMA.
module horner_sequencer
  import nla_pkg::*;
#(
  parameter int unsigned DATA_W     = NLA_DATA_W,
  parameter int unsigned NUM_COEFFS = NLA_NUM_COEFFS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] x_i,
  output logic              coeff_rd_en_o,
  output logic              coeff_reload_o,
  input  logic [DATA_W-1:0] coeff_data_i,
  output logic              fma_valid_o,
  input  logic              fma_ready_i,
  output logic [DATA_W-1:0] fma_a_o,
  output logic [DATA_W-1:0] fma_b_o,
  output logic [DATA_W-1:0] fma_c_o,
  input  logic              fma_res_valid_i,
  input  logic [DATA_W-1:0] fma_res_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int unsigned CNT_W = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_COEFFS - 1);

  nla_state_e        state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] coeff_q, coeff_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              in_ready_q, in_ready_d;
  logic              reload_q, reload_d;
  logic              rd_en_q, rd_en_d;
  logic              fma_valid_q, fma_valid_d;
  logic              out_valid_q, out_valid_d;

  // Next-state and datapath updates; outputs are decoded from the next state
  // so every pulse/valid flop lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    acc_d    = acc_q;
    coeff_d  = coeff_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          x_d     = x_i;
          state_d = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        cnt_d   = '0;
        first_d = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (first_q) begin
          acc_d   = coeff_data_i;
          first_d = 1'b0;
          state_d = (NUM_COEFFS == 1) ? ST_DONE : ST_FETCH;
        end else begin
          coeff_d = coeff_data_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fma_ready_i) begin
          state_d = ST_WAIT_FMA;
        end
      end
      ST_WAIT_FMA: begin
        if (fma_res_valid_i) begin
          acc_d   = fma_res_i;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == LAST_CNT) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_DONE) begin
      result_d = acc_d;
    end

    in_ready_d  = (state_d == ST_IDLE);
    reload_d    = (state_d == ST_RELOAD);
    rd_en_d     = (state_d == ST_FETCH);
    fma_valid_d = (state_d == ST_ISSUE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      acc_q       <= '0;
      coeff_q     <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      reload_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      fma_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      coeff_q     <= coeff_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      reload_q    <= reload_d;
      rd_en_q     <= rd_en_d;
      fma_valid_q <= fma_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign coeff_reload_o = reload_q;
  assign coeff_rd_en_o  = rd_en_q;
  assign fma_valid_o    = fma_valid_q;
  assign fma_a_o        = acc_q;
  assign fma_b_o        = x_q;
  assign fma_c_o        = coeff_q;
  assign out_valid_o    = out_valid_q;
  assign result_o       = result_q;

endmodule
